i2s_tx_stream: RTL

Parametrised I2S serial transmitter that carries both stereo channels. It replaces fixed-pattern test transmitters in the audio output path.
- Accepts stereo sample pairs over a valid/ready handshake into a one-deep holding buffer.
- Serialises each pair MSB-first onto sound_bit_out, with word_select framing.
- Supports Philips I2S (one-bit delay) and left-justified framing.
- Reports underruns as a one-cycle flag plus a saturating counter.

---
 rtl/i2s_pkg.sv | 23 ++
 rtl/i2s_pair_buffer.sv | 38 +++
 rtl/i2s_tx_stream.sv | 102 ++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S stereo transmitter slice.
package i2s_pkg;

  // Pair storage is sized for the widest supported sample; narrower
  // samples sit in the low bits and the upper bits stay zero.
  localparam int unsigned I2S_MAX_DATA_W = 32;
  localparam int unsigned I2S_PAIR_W     = 2 * I2S_MAX_DATA_W;

  typedef struct packed {
    logic [I2S_MAX_DATA_W-1:0] left;
    logic [I2S_MAX_DATA_W-1:0] right;
  } i2s_pair_t;

  typedef enum logic {
    I2S_LEFT_JUST = 1'b0,
    I2S_PHILIPS   = 1'b1
  } i2s_mode_e;

  function automatic int unsigned frame_len(input int unsigned slot_w);
    return 2 * slot_w;
  endfunction

endpackage

// File: rtl/i2s_pair_buffer.sv
// One-deep holding register for stereo pairs; a drain and a push may coincide.
module i2s_pair_buffer
  import i2s_pkg::*;
(
  input  logic                  serial_clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [I2S_PAIR_W-1:0] in_pair,
  input  logic                  drain,
  output logic                  full,
  output logic [I2S_PAIR_W-1:0] drain_pair
);

  i2s_pair_t held;
  logic      push;

  always_comb begin
    in_ready = !full || drain;
    push     = in_valid && in_ready;
  end

  // A push in the drain cycle refills the slot, so full stays set.
  always_ff @(posedge serial_clk) begin
    if (reset) begin
      full <= 1'b0;
      held <= '0;
    end else if (push) begin
      full <= 1'b1;
      held <= in_pair;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  assign drain_pair = held;

endmodule

// File: rtl/i2s_tx_stream.sv
// Stereo I2S serialiser: free-running frame position, registered framing and
// data outputs, underrun reporting when a frame starts with no buffered pair.
module i2s_tx_stream
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SLOT_W   = 17,
  parameter int unsigned I2S_MODE = 1,
  parameter int unsigned UCNT_W   = 16
) (
  input  logic              serial_clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              word_select,
  output logic              sound_bit_out,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_count
);

  localparam int unsigned FRAME_LEN = frame_len(SLOT_W);
  localparam int unsigned POS_W     = $clog2(FRAME_LEN);
  localparam int unsigned BIT_W     = $clog2(I2S_MAX_DATA_W);
  localparam i2s_mode_e   MODE      = (I2S_MODE != 0) ? I2S_PHILIPS : I2S_LEFT_JUST;
  localparam int unsigned OFF       = (MODE == I2S_PHILIPS) ? 1 : 0;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);
  localparam logic [POS_W-1:0] POS_SLOT = POS_W'(SLOT_W);
  localparam logic [POS_W-1:0] POS_L0   = POS_W'(OFF);
  localparam logic [POS_W-1:0] POS_R0   = POS_W'(SLOT_W + OFF);
  localparam logic [POS_W-1:0] POS_DW   = POS_W'(DATA_W);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(DATA_W - 1);

  logic [POS_W-1:0]          pos;
  logic [POS_W-1:0]          pos_next;
  logic [POS_W-1:0]          rel;
  logic                      load_edge;
  logic                      buf_full;
  logic                      right_slot;
  logic                      bit_next;
  logic [BIT_W-1:0]          bit_sel;
  logic [I2S_MAX_DATA_W-1:0] word;
  i2s_pair_t                 in_pair;
  i2s_pair_t                 drain_pair;
  i2s_pair_t                 cur_pair;
  i2s_pair_t                 frame_next;

  always_comb begin
    in_pair.left  = I2S_MAX_DATA_W'(in_left);
    in_pair.right = I2S_MAX_DATA_W'(in_right);
  end

  i2s_pair_buffer u_buffer (
    .serial_clk (serial_clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pair    (in_pair),
    .drain      (load_edge),
    .full       (buf_full),
    .drain_pair (drain_pair)
  );

  // Outputs are registered, so everything is computed for the position the
  // next edge enters. A position before a slot's first bit wraps rel high.
  always_comb begin
    load_edge  = (pos == POS_LAST);
    pos_next   = load_edge ? '0 : pos + 1'b1;
    frame_next = cur_pair;
    if (load_edge) begin
      frame_next = buf_full ? drain_pair : '0;
    end
    right_slot = (pos_next >= POS_SLOT);
    rel        = pos_next - (right_slot ? POS_R0 : POS_L0);
    word       = right_slot ? frame_next.right : frame_next.left;
    bit_sel    = BIT_TOP - BIT_W'(rel);
    bit_next   = (rel < POS_DW) ? word[bit_sel] : 1'b0;
  end

  always_ff @(posedge serial_clk) begin
    if (reset) begin
      pos            <= '0;
      cur_pair       <= '0;
      word_select    <= 1'b0;
      sound_bit_out  <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      pos           <= pos_next;
      cur_pair      <= frame_next;
      word_select   <= right_slot;
      sound_bit_out <= bit_next;
      underrun      <= load_edge && !buf_full;
      if (load_edge && !buf_full && (underrun_count != '1)) begin
        underrun_count <= underrun_count + 1'b1;
      end
    end
  end

endmodule
